// File: rtl/cfg_init_pkg.sv
// Shared types and defaults for the configuration-initialisation sequencer.
package cfg_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WRITE,
        ST_FINISH,
        ST_DONE,
        ST_ERROR
    } cfg_init_state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYC = 16;

    // Address width for a table of n entries, never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/init_timeout_cnt.sv
// Write-stall timeout counter: clear, enable and terminal-count flag.
// The flag is held low when TIMEOUT_CYC is 0, which disables the timeout.
module init_timeout_cnt
    import cfg_init_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned TC_VAL = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    logic [CNT_W-1:0] cnt;

    // Count stalled cycles; clear has priority over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TC_VAL));

endmodule

// File: rtl/cfg_init_seq.sv
// Configuration-initialisation sequencer: walks INIT_VALS and writes each
// entry over a valid/ready port, keeping a shadow copy of accepted values.
module cfg_init_seq
    import cfg_init_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = addr_width(NUM_REGS),
    parameter logic [NUM_REGS*DATA_W-1:0] INIT_VALS = '0,
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reinit_req,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic [NUM_REGS*DATA_W-1:0] shadow_q,
    output logic                       init_done,
    output logic                       init_err,
    output logic                       handshake_start,
    output logic                       handshake_end
);

    cfg_init_state_e   state;
    logic              go_start;
    logic              accept;
    logic              last_idx;
    logic              to_clr;
    logic              to_en;
    logic              to_tc;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] next_val;

    assign go_start = (state == ST_IDLE) ||
                      (((state == ST_DONE) || (state == ST_ERROR)) && reinit_req);
    assign accept   = (state == ST_WRITE) && wr_valid && wr_ready;
    assign last_idx = (wr_addr == ADDR_W'(NUM_REGS - 1));
    assign to_clr   = (state == ST_START) || accept;
    assign to_en    = (state == ST_WRITE) && !accept;

    init_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (to_clr),
        .en  (to_en),
        .tc  (to_tc)
    );

    // Index the next write will present: restart at 0, otherwise advance.
    assign next_addr = go_start ? '0 : wr_addr + ADDR_W'(1);

    // Look up the table entry for next_addr so wr_data is registered with it.
    always_comb begin
        next_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (next_addr == ADDR_W'(i)) begin
                next_val = INIT_VALS[i*DATA_W +: DATA_W];
            end
        end
    end

    // Sequencer FSM with all outputs registered.
    // Entry into START is shared by the reset path and re-init from DONE/ERROR,
    // so it is handled ahead of the per-state case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            wr_valid        <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            shadow_q        <= '0;
            init_done       <= 1'b0;
            init_err        <= 1'b0;
            handshake_start <= 1'b0;
            handshake_end   <= 1'b0;
        end else begin
            handshake_start <= 1'b0;
            handshake_end   <= 1'b0;
            if (go_start) begin
                state           <= ST_START;
                handshake_start <= 1'b1;
                init_done       <= 1'b0;
                init_err        <= 1'b0;
                wr_valid        <= 1'b0;
                wr_addr         <= next_addr;
                wr_data         <= next_val;
            end else begin
                case (state)
                    ST_START: begin
                        state    <= ST_WRITE;
                        wr_valid <= 1'b1;
                    end
                    ST_WRITE: begin
                        if (accept) begin
                            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                                if (wr_addr == ADDR_W'(i)) begin
                                    shadow_q[i*DATA_W +: DATA_W] <= wr_data;
                                end
                            end
                            if (last_idx) begin
                                state         <= ST_FINISH;
                                wr_valid      <= 1'b0;
                                handshake_end <= 1'b1;
                                init_done     <= 1'b1;
                            end else begin
                                wr_addr <= next_addr;
                                wr_data <= next_val;
                            end
                        end else if (to_tc) begin
                            state         <= ST_ERROR;
                            wr_valid      <= 1'b0;
                            init_err      <= 1'b1;
                            handshake_end <= 1'b1;
                        end
                    end
                    ST_FINISH: begin
                        state <= ST_DONE;
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cfg_init_seq.sv
// Self-checking bench for cfg_init_seq: table-driven timing vectors,
// hand-written corner sequences and randomized stalls against a model.
module tb_cfg_init_seq;

    localparam int NR  = 8;
    localparam int DW  = 32;
    localparam int TO  = 16;

    function automatic logic [NR*DW-1:0] mk_init();
        logic [NR*DW-1:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = 32'hA500_0000 + 32'(i);
        return r;
    endfunction

    localparam logic [NR*DW-1:0] INIT8 = mk_init();

    function automatic logic [31:0] ival(input int i);
        return 32'hA500_0000 + 32'(i);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-entry instance
    logic             rst8, reinit8, ready8;
    logic             valid8, done8, err8, start8, end8;
    logic [2:0]       addr8;
    logic [DW-1:0]    data8;
    logic [NR*DW-1:0] shadow8;

    cfg_init_seq #(
        .NUM_REGS    (NR),
        .DATA_W      (DW),
        .INIT_VALS   (INIT8),
        .TIMEOUT_CYC (TO)
    ) dut8 (
        .clk             (clk),
        .rst             (rst8),
        .reinit_req      (reinit8),
        .wr_valid        (valid8),
        .wr_ready        (ready8),
        .wr_addr         (addr8),
        .wr_data         (data8),
        .shadow_q        (shadow8),
        .init_done       (done8),
        .init_err        (err8),
        .handshake_start (start8),
        .handshake_end   (end8)
    );

    // single-entry instance, timeout disabled
    logic          rst1, reinit1, ready1;
    logic          valid1, done1, err1, start1, end1;
    logic [0:0]    addr1;
    logic [DW-1:0] data1;
    logic [DW-1:0] shadow1;

    cfg_init_seq #(
        .NUM_REGS    (1),
        .DATA_W      (DW),
        .INIT_VALS   (32'hDEAD_BEEF),
        .TIMEOUT_CYC (0)
    ) dut1 (
        .clk             (clk),
        .rst             (rst1),
        .reinit_req      (reinit1),
        .wr_valid        (valid1),
        .wr_ready        (ready1),
        .wr_addr         (addr1),
        .wr_data         (data1),
        .shadow_q        (shadow1),
        .init_done       (done1),
        .init_err        (err1),
        .handshake_start (start1),
        .handshake_end   (end1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        st;
        logic        vl;
        logic [2:0]  ad;
        logic [31:0] da;
        logic        en;
        logic        dn;
    } vec_t;

    vec_t tbl[1:11];

    // Cycle-by-cycle check of a full sequence with wr_ready high. Cycle 1 is
    // the cycle after the edge that starts the sequence. With poke set,
    // reinit_req is held during several WRITE cycles and must be ignored.
    task automatic run_table(input bit poke);
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1) reinit8 = 1'b0;
            chk($sformatf("c%0d_start", c), NR*DW'(start8), NR*DW'(tbl[c].st));
            chk($sformatf("c%0d_valid", c), NR*DW'(valid8), NR*DW'(tbl[c].vl));
            chk($sformatf("c%0d_end", c),   NR*DW'(end8),   NR*DW'(tbl[c].en));
            chk($sformatf("c%0d_done", c),  NR*DW'(done8),  NR*DW'(tbl[c].dn));
            chk($sformatf("c%0d_err", c),   NR*DW'(err8),   '0);
            if (tbl[c].vl) begin
                chk($sformatf("c%0d_addr", c), NR*DW'(addr8), NR*DW'(tbl[c].ad));
                chk($sformatf("c%0d_data", c), NR*DW'(data8), NR*DW'(tbl[c].da));
            end
            reinit8 = poke && (c >= 2) && (c <= 4);
        end
    endtask

    // One re-init round with random stalls; model is a queue of pending
    // addresses plus the rule that every stall costs exactly one cycle.
    task automatic random_round(input int round);
        int q[$];
        int stalls = 0;
        int consec = 0;
        int cyc;
        bit ended = 0;
        bit rdy;
        bit v;
        logic [2:0]  a;
        logic [31:0] d;
        for (int i = 0; i < NR; i++) q.push_back(i);
        reinit8 = 1'b1;
        tick();
        reinit8 = 1'b0;
        cyc = 1;
        chk($sformatf("r%0d_start", round), NR*DW'(start8), NR*DW'(1'b1));
        while (!ended && cyc < 200) begin
            v = valid8;
            a = addr8;
            d = data8;
            if (v) begin
                if (q.size() == 0) begin
                    chk($sformatf("r%0d_extra_write", round), NR*DW'(1'b1), '0);
                end else begin
                    chk($sformatf("r%0d_addr", round), NR*DW'(a), NR*DW'(q[0]));
                    chk($sformatf("r%0d_data", round), NR*DW'(d), NR*DW'(ival(q[0])));
                end
            end
            rdy = (consec >= TO - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            ready8 = rdy;
            tick();
            cyc++;
            if (v && rdy) begin
                if (q.size() != 0) void'(q.pop_front());
                consec = 0;
            end else if (v) begin
                stalls++;
                consec++;
            end
            if (end8) ended = 1;
        end
        chk($sformatf("r%0d_ended", round), NR*DW'(ended), NR*DW'(1'b1));
        chk($sformatf("r%0d_end_cycle", round), NR*DW'(cyc), NR*DW'(NR + 2 + stalls));
        chk($sformatf("r%0d_all_accepted", round), NR*DW'(q.size()), '0);
        chk($sformatf("r%0d_done", round), NR*DW'(done8), NR*DW'(1'b1));
        chk($sformatf("r%0d_err", round), NR*DW'(err8), '0);
        chk($sformatf("r%0d_shadow", round), shadow8, INIT8);
        tick();
    endtask

    initial begin
        bit seen;
        int cyc;
        int stall;
        logic [NR*DW-1:0] exp_sh;

        // expected timing table for a stall-free run
        for (int c = 1; c <= 11; c++) begin
            tbl[c].st = (c == 1);
            tbl[c].vl = (c >= 2) && (c <= NR + 1);
            tbl[c].ad = 3'((c >= 2) ? c - 2 : 0);
            tbl[c].da = ival((c >= 2) ? c - 2 : 0);
            tbl[c].en = (c == NR + 2);
            tbl[c].dn = (c >= NR + 2);
        end

        rst8 = 1'b1; reinit8 = 1'b0; ready8 = 1'b1;
        rst1 = 1'b1; reinit1 = 1'b0; ready1 = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_valid",  NR*DW'(valid8), '0);
        chk("rst_addr",   NR*DW'(addr8),  '0);
        chk("rst_data",   NR*DW'(data8),  '0);
        chk("rst_shadow", shadow8,        '0);
        chk("rst_flags",  NR*DW'({done8, err8, start8, end8}), '0);

        // nominal sequence after reset
        rst8 = 1'b0;
        run_table(1'b0);
        chk("nominal_shadow", shadow8, INIT8);

        // re-init from DONE, with reinit_req also raised during WRITE
        reinit8 = 1'b1;
        run_table(1'b1);
        chk("reinit_shadow", shadow8, INIT8);

        // timeout on index 3
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        ready8 = 1'b1;
        seen = 0;
        cyc = 0;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (valid8 && addr8 == 3'd3) seen = 1;
        end
        chk("to_reach_idx3", NR*DW'(seen), NR*DW'(1'b1));
        chk("to_idx3_cycle", NR*DW'(cyc), NR*DW'(5));
        ready8 = 1'b0;
        for (stall = 1; stall <= TO; stall++) begin
            tick();
            if (stall < TO) begin
                chk($sformatf("to_s%0d_err", stall),   NR*DW'(err8),   '0);
                chk($sformatf("to_s%0d_valid", stall), NR*DW'(valid8), NR*DW'(1'b1));
                chk($sformatf("to_s%0d_addr", stall),  NR*DW'(addr8),  NR*DW'(3));
            end
        end
        chk("to_err",   NR*DW'(err8),   NR*DW'(1'b1));
        chk("to_end",   NR*DW'(end8),   NR*DW'(1'b1));
        chk("to_done",  NR*DW'(done8),  '0);
        tick();
        chk("to_after_valid", NR*DW'(valid8), '0);
        chk("to_after_end",   NR*DW'(end8),   '0);
        chk("to_after_err",   NR*DW'(err8),   NR*DW'(1'b1));
        exp_sh = '0;
        for (int i = 0; i < 3; i++) exp_sh[i*DW +: DW] = ival(i);
        chk("to_shadow", shadow8, exp_sh);

        // re-init out of ERROR
        reinit8 = 1'b1;
        tick();
        reinit8 = 1'b0;
        chk("err_reinit_start", NR*DW'(start8), NR*DW'(1'b1));
        chk("err_reinit_err",   NR*DW'(err8),   '0);

        // asynchronous reset at index 5
        ready8 = 1'b1;
        seen = 0;
        cyc = 0;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (valid8 && addr8 == 3'd5) seen = 1;
        end
        chk("ar_reach_idx5", NR*DW'(seen), NR*DW'(1'b1));
        #2 rst8 = 1'b1;
        #1;
        chk("ar_valid",  NR*DW'(valid8), '0);
        chk("ar_addr",   NR*DW'(addr8),  '0);
        chk("ar_data",   NR*DW'(data8),  '0);
        chk("ar_shadow", shadow8,        '0);
        chk("ar_flags",  NR*DW'({done8, err8, start8, end8}), '0);
        tick();
        rst8 = 1'b0;
        tick();
        chk("ar_restart_start", NR*DW'(start8), NR*DW'(1'b1));
        tick();
        chk("ar_restart_valid", NR*DW'(valid8), NR*DW'(1'b1));
        chk("ar_restart_addr",  NR*DW'(addr8),  '0);
        chk("ar_restart_data",  NR*DW'(data8),  NR*DW'(ival(0)));

        // let it complete, then step into DONE
        seen = 0;
        cyc = 0;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (done8) seen = 1;
        end
        chk("ar_complete", NR*DW'(seen), NR*DW'(1'b1));
        tick();

        // randomized stalls
        for (int r = 0; r < 6; r++) random_round(r);

        // single entry, timeout disabled, long stall
        rst1 = 1'b0;
        ready1 = 1'b0;
        tick();
        chk("n1_start", NR*DW'(start1), NR*DW'(1'b1));
        tick();
        chk("n1_valid", NR*DW'(valid1), NR*DW'(1'b1));
        chk("n1_data",  NR*DW'(data1),  NR*DW'(32'hDEAD_BEEF));
        for (int i = 0; i < 100; i++) begin
            tick();
            if (err1 !== 1'b0 || valid1 !== 1'b1 || end1 !== 1'b0)
                chk($sformatf("n1_stall%0d", i), NR*DW'({err1, valid1, end1}), NR*DW'(3'b010));
        end
        chk("n1_stall_err",   NR*DW'(err1),   '0);
        chk("n1_stall_valid", NR*DW'(valid1), NR*DW'(1'b1));
        ready1 = 1'b1;
        tick();
        chk("n1_end",    NR*DW'(end1),    NR*DW'(1'b1));
        chk("n1_done",   NR*DW'(done1),   NR*DW'(1'b1));
        chk("n1_err",    NR*DW'(err1),    '0);
        chk("n1_shadow", NR*DW'(shadow1), NR*DW'(32'hDEAD_BEEF));

        // single entry with ready high: end at cycle 3
        tick();
        reinit1 = 1'b1;
        tick();
        reinit1 = 1'b0;
        chk("n1r_c1_start", NR*DW'(start1), NR*DW'(1'b1));
        chk("n1r_c1_done",  NR*DW'(done1),  '0);
        tick();
        chk("n1r_c2_valid", NR*DW'(valid1), NR*DW'(1'b1));
        chk("n1r_c2_end",   NR*DW'(end1),   '0);
        tick();
        chk("n1r_c3_end",   NR*DW'(end1),   NR*DW'(1'b1));
        chk("n1r_c3_done",  NR*DW'(done1),  NR*DW'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
